// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for a single-port memory with registered grants and a hold-limit preemption.
// Optional macro ARB_ROUND_ROBIN_EN: alternate the winner of contention from idle.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_HOLD   = 64,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m0_we_n,
    output logic                  m0_gnt,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_we_n,
    output logic                  m1_gnt,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  preempt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we_n,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Grant flops double as the state register: bit 0 is m0_gnt, bit 1 is m1_gnt.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOwn0 = 2'b01,
        StOwn1 = 2'b10
    } state_e;

    localparam bit PreemptEn = (MAX_HOLD > 0);
    localparam logic [CNT_WIDTH-1:0] HoldLast = PreemptEn ? CNT_WIDTH'(MAX_HOLD - 1) : '0;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic                 last_owner_q, last_owner_d;
    logic                 preempt_q, preempt_d;
    logic                 hold_expired;

    assign hold_expired = PreemptEn && (hold_cnt_q == HoldLast);

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        last_owner_d = last_owner_q;
        preempt_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    state_d = last_owner_q ? StOwn0 : StOwn1;
`else
                    state_d = StOwn0;
`endif
                end else if (m0_req) begin
                    state_d = StOwn0;
                end else if (m1_req) begin
                    state_d = StOwn1;
                end
            end
            // A release on the same edge as an expired hold wins, so no pulse.
            StOwn0: begin
                if (!m0_req) begin
                    state_d = m1_req ? StOwn1 : StIdle;
                end else if (m1_req && hold_expired) begin
                    state_d   = StOwn1;
                    preempt_d = 1'b1;
                end
            end
            StOwn1: begin
                if (!m1_req) begin
                    state_d = m0_req ? StOwn0 : StIdle;
                end else if (m0_req && hold_expired) begin
                    state_d   = StOwn0;
                    preempt_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            hold_cnt_d = '0;
            if (state_d == StOwn0) begin
                last_owner_d = 1'b0;
            end else if (state_d == StOwn1) begin
                last_owner_d = 1'b1;
            end
        end else if (state_q != StIdle && PreemptEn && !hold_expired) begin
            hold_cnt_d = hold_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            hold_cnt_q   <= '0;
            last_owner_q <= 1'b1;
            preempt_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            last_owner_q <= last_owner_d;
            preempt_q    <= preempt_d;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we_n  = 1'b1;
        unique case (state_q)
            StOwn0: begin
                mem_addr  = m0_addr;
                mem_wdata = m0_wdata;
                mem_we_n  = m0_we_n;
            end
            StOwn1: begin
                mem_addr  = m1_addr;
                mem_wdata = m1_wdata;
                mem_we_n  = m1_we_n;
            end
            default: ;
        endcase
    end

    assign m0_gnt  = state_q[0];
    assign m1_gnt  = state_q[1];
    assign preempt = preempt_q;
    assign rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (hold limit 4 and 0) share stimulus and are
// checked every cycle against an owner/cycle-count model plus directed literal checks.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m0_we_n, m1_req, m1_we_n;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        m0_gnt_a, m1_gnt_a, preempt_a, mem_we_n_a;
    logic [15:0] rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic        m0_gnt_b, m1_gnt_b, preempt_b, mem_we_n_b;
    logic [15:0] rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:255];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MAX_HOLD(4), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we_n(m0_we_n),
        .m0_gnt(m0_gnt_a),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we_n(m1_we_n),
        .m1_gnt(m1_gnt_a),
        .rdata(rdata_a), .preempt(preempt_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_we_n(mem_we_n_a), .mem_rdata(mem_rdata_a)
    );

    mem_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MAX_HOLD(0), .CNT_WIDTH(8)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we_n(m0_we_n),
        .m0_gnt(m0_gnt_b),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we_n(m1_we_n),
        .m1_gnt(m1_gnt_b),
        .rdata(rdata_b), .preempt(preempt_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_we_n(mem_we_n_b), .mem_rdata(mem_rdata_b)
    );

    // Synchronous-read memories, one per instance.
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'hA000 | 16'(i);
            mem_b[i] = 16'hA000 | 16'(i);
        end
    end

    always @(posedge clk) begin
        if (!mem_we_n_a) mem_a[mem_addr_a[7:0]] <= mem_wdata_a;
        if (!mem_we_n_b) mem_b[mem_addr_b[7:0]] <= mem_wdata_b;
        mem_rdata_a <= mem_a[mem_addr_a[7:0]];
        mem_rdata_b <= mem_b[mem_addr_b[7:0]];
    end

    // Model: owner (-1 none), cycles owned since grant, last owner, preempt pulse.
    int m_own  [2];
    int m_held [2];
    int m_last [2];
    bit m_pre  [2];
    bit m_valid = 1'b0;
    int m_maxh [2] = '{4, 0};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int nxt;
            bit p;
            bit rx, ry;
            p = 1'b0;
            if (!reset_n) begin
                m_own[k]  <= -1;
                m_held[k] <= 0;
                m_last[k] <= 1;
                m_pre[k]  <= 1'b0;
            end else begin
                if (m_own[k] == -1) begin
                    if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                        nxt = 1 - m_last[k];
`else
                        nxt = 0;
`endif
                    end else if (m0_req) nxt = 0;
                    else if (m1_req) nxt = 1;
                    else nxt = -1;
                end else begin
                    rx = (m_own[k] == 0) ? m0_req : m1_req;
                    ry = (m_own[k] == 0) ? m1_req : m0_req;
                    if (!rx) nxt = ry ? 1 - m_own[k] : -1;
                    else if (m_maxh[k] > 0 && ry && m_held[k] >= m_maxh[k] - 1) begin
                        nxt = 1 - m_own[k];
                        p   = 1'b1;
                    end else nxt = m_own[k];
                end
                if (nxt != m_own[k]) m_held[k] <= 0;
                else if (nxt != -1) m_held[k] <= m_held[k] + 1;
                if (nxt != -1 && nxt != m_own[k]) m_last[k] <= nxt;
                m_own[k] <= nxt;
                m_pre[k] <= p;
            end
        end
        if (!reset_n) m_valid <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string tag, input int k, input logic g0, input logic g1,
                            input logic pre, input logic [15:0] addr, input logic [15:0] wd,
                            input logic we_n, input logic [15:0] rd, input logic [15:0] mrd);
        logic [15:0] ea, ew;
        logic        ewe;
        ea  = (m_own[k] == 0) ? m0_addr  : (m_own[k] == 1) ? m1_addr  : 16'h0;
        ew  = (m_own[k] == 0) ? m0_wdata : (m_own[k] == 1) ? m1_wdata : 16'h0;
        ewe = (m_own[k] == 0) ? m0_we_n  : (m_own[k] == 1) ? m1_we_n  : 1'b1;
        chk({tag, "_m0_gnt"}, 32'(g0), 32'(m_own[k] == 0));
        chk({tag, "_m1_gnt"}, 32'(g1), 32'(m_own[k] == 1));
        chk({tag, "_no_overlap"}, 32'(g0 & g1), 32'h0);
        chk({tag, "_preempt"}, 32'(pre), 32'(m_pre[k]));
        chk({tag, "_mem_addr"}, 32'(addr), 32'(ea));
        chk({tag, "_mem_wdata"}, 32'(wd), 32'(ew));
        chk({tag, "_mem_we_n"}, 32'(we_n), 32'(ewe));
        chk({tag, "_rdata"}, 32'(rd), 32'(mrd));
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            cmp_inst("a", 0, m0_gnt_a, m1_gnt_a, preempt_a, mem_addr_a, mem_wdata_a, mem_we_n_a,
                     rdata_a, mem_rdata_a);
            cmp_inst("b", 1, m0_gnt_b, m1_gnt_b, preempt_b, mem_addr_b, mem_wdata_b, mem_we_n_b,
                     rdata_b, mem_rdata_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int w, cnt, pc;
    int order [3];
    int exp_order [3];

    initial begin
        reset_n = 1'b0;
        m0_req = 0; m0_addr = 0; m0_wdata = 0; m0_we_n = 1;
        m1_req = 0; m1_addr = 0; m1_wdata = 0; m1_we_n = 1;
        tick();
        tick();
        reset_n = 1'b1;

        // Reset mid-write while M1 owns the bus.
        m1_req = 1;
        chk("gnt_latency_pre", 32'(m1_gnt_a), 32'h0);
        tick();
        chk("m1_granted", 32'(m1_gnt_a), 32'h1);
        m1_we_n = 0; m1_addr = 16'h0044; m1_wdata = 16'h7777;
        reset_n = 1'b0;
        tick();
        chk("rst_m1_gnt", 32'(m1_gnt_a), 32'h0);
        chk("rst_mem_we_n", 32'(mem_we_n_a), 32'h1);
        chk("rst_mem_addr", 32'(mem_addr_a), 32'h0);
        chk("rst_preempt", 32'(preempt_a), 32'h0);
        tick();
        reset_n = 1'b1; m1_req = 0; m1_we_n = 1; m1_addr = 0; m1_wdata = 0;
        tick();

        // Single master write then read back.
        m0_req = 1; m0_addr = 16'h0010; m0_wdata = 16'h1234; m0_we_n = 0;
        tick();
        chk("single_m0_gnt", 32'(m0_gnt_a), 32'h1);
        chk("single_we_n", 32'(mem_we_n_a), 32'h0);
        chk("single_addr", 32'(mem_addr_a), 32'h0010);
        tick();
        m0_we_n = 1;
        tick();
        chk("single_rdata", 32'(rdata_a), 32'h1234);
        m0_req = 0;
        tick();

        // Contention from idle, then direct handover.
        m0_req = 1; m1_req = 1; m0_addr = 16'h0001; m1_addr = 16'h0002;
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        w = 1;
`else
        w = 0;
`endif
        chk("cont_first", 32'(m1_gnt_a ? 1 : 0), 32'(w));
        if (w == 0) m0_req = 0; else m1_req = 0;
        tick();
        chk("handover_m0", 32'(m0_gnt_a), 32'(w == 1));
        chk("handover_m1", 32'(m1_gnt_a), 32'(w == 0));
        m0_req = 0; m1_req = 0;
        tick();

        // Preemption: limit 4 in dut_a, none in dut_b.
        m0_req = 1;
        tick();
        m1_req = 1;
        cnt = m0_gnt_a ? 1 : 0;
        pc = 0;
        for (int i = 0; i < 10 && !m1_gnt_a; i++) begin
            tick();
            if (m0_gnt_a) cnt++;
            if (preempt_a) pc++;
        end
        chk("preempt_hold_cycles", 32'(cnt), 32'd4);
        chk("preempt_pulses", 32'(pc), 32'd1);
        chk("preempt_m1_gnt", 32'(m1_gnt_a), 32'h1);
        tick();
        chk("preempt_one_cycle", 32'(preempt_a), 32'h0);
        tick();
        tick();
        chk("nolimit_m0_keeps", 32'(m0_gnt_b), 32'h1);
        chk("nolimit_m1_waits", 32'(m1_gnt_b), 32'h0);
        chk("nolimit_no_preempt", 32'(preempt_b), 32'h0);
        m0_req = 0; m1_req = 0;
        tick();

        // Write gating: M1 strobes while M0 owns.
        m0_req = 1; m0_addr = 16'h0030; m0_we_n = 1;
        m1_addr = 16'h0020; m1_wdata = 16'hBEEF; m1_we_n = 0;
        tick();
        chk("gate_we_n", 32'(mem_we_n_a), 32'h1);
        chk("gate_addr", 32'(mem_addr_a), 32'h0030);
        tick();
        tick();
        m0_req = 0;
        tick();
        m1_we_n = 1; m1_req = 1;
        tick();
        tick();
        chk("gate_old_value_a", 32'(rdata_a), 32'h0000A020);
        chk("gate_old_value_b", 32'(rdata_b), 32'h0000A020);
        m1_req = 0;
        tick();

        // Three rounds of simultaneous requests from idle.
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0};
`else
        exp_order = '{0, 0, 0};
`endif
        for (int r = 0; r < 3; r++) begin
            m0_req = 1; m1_req = 1;
            tick();
            order[r] = m1_gnt_a ? 1 : 0;
            chk("round_one_gnt", 32'(m0_gnt_a ^ m1_gnt_a), 32'h1);
            tick();
            m0_req = 0; m1_req = 0;
            tick();
        end
        for (int r = 0; r < 3; r++) chk($sformatf("round_order_%0d", r), 32'(order[r]),
                                        32'(exp_order[r]));

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
